// File: rtl/wb_stage_regfile.sv
// Write-back stage and 32x32 architectural register file.
// Forms the write-back value/destination, commits it, and serves two bypassed read ports.
module wb_stage_regfile #(
  parameter int DW      = 32,
  parameter int NREG    = 32,
  parameter int LINK_RA = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] Result_in,
  input  logic [DW-1:0] dm_read_in,
  input  logic [4:0]    rt_in,
  input  logic [4:0]    rd_in,
  input  logic          RegDst_in,
  input  logic          MemtoReg_in,
  input  logic          RegWr_in,
  input  logic          ExtopM_in,
  input  logic          IsLink_in,
  input  logic          IsByteW_in,
  input  logic [4:0]    ra1,
  input  logic [4:0]    ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          wb_we,
  output logic [4:0]    wb_addr,
  output logic [DW-1:0] wb_data
);

  localparam logic [4:0] LINK_ADDR = 5'(LINK_RA);

  logic [DW-1:0] regs [NREG];
  logic [7:0]    byte_sel;
  logic [DW-1:0] byte_ext;

  always_comb begin
    byte_sel = dm_read_in[7:0];
    case (Result_in[1:0])
      2'd0: byte_sel = dm_read_in[7:0];
      2'd1: byte_sel = dm_read_in[15:8];
      2'd2: byte_sel = dm_read_in[23:16];
      2'd3: byte_sel = dm_read_in[31:24];
      default: byte_sel = dm_read_in[7:0];
    endcase
    byte_ext = {{(DW-8){ExtopM_in & byte_sel[7]}}, byte_sel};
  end

  always_comb begin
    wb_addr = RegDst_in ? rd_in : rt_in;
    if (IsLink_in) wb_addr = LINK_ADDR;
  end

  always_comb begin
    if (IsLink_in)                       wb_data = pc_in + DW'(4);
    else if (MemtoReg_in && IsByteW_in)  wb_data = byte_ext;
    else if (MemtoReg_in)                wb_data = dm_read_in;
    else                                 wb_data = Result_in;
  end

  // rst_n gates the enable so a write can never land while reset is held
  assign wb_we = RegWr_in & (wb_addr != 5'd0) & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    if (!rst_n || ra1 == 5'd0)       rd1 = '0;
    else if (wb_we && ra1 == wb_addr) rd1 = wb_data;
    else                              rd1 = regs[ra1];
  end

  always_comb begin
    if (!rst_n || ra2 == 5'd0)       rd2 = '0;
    else if (wb_we && ra2 == wb_addr) rd2 = wb_data;
    else                              rd2 = regs[ra2];
  end

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed bench for wb_stage_regfile: expected values queued at drive time, popped at sample time.
module tb_wb_stage_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in, Result_in, dm_read_in;
  logic [4:0]  rt_in, rd_in, ra1, ra2;
  logic        RegDst_in, MemtoReg_in, RegWr_in, ExtopM_in, IsLink_in, IsByteW_in;
  logic [31:0] rd1, rd2, wb_data;
  logic        wb_we;
  logic [4:0]  wb_addr;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wb_stage_regfile dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .Result_in(Result_in),
    .dm_read_in(dm_read_in), .rt_in(rt_in), .rd_in(rd_in),
    .RegDst_in(RegDst_in), .MemtoReg_in(MemtoReg_in), .RegWr_in(RegWr_in),
    .ExtopM_in(ExtopM_in), .IsLink_in(IsLink_in), .IsByteW_in(IsByteW_in),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h expected <queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // inputs change on negedge like the MEM/WB register; sample 1ns later
  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; pc_in = '0; Result_in = 32'h1234; dm_read_in = '0;
    rt_in = '0; rd_in = 5'd5; RegDst_in = 1'b1; MemtoReg_in = 1'b0;
    RegWr_in = 1'b1; ExtopM_in = 1'b0; IsLink_in = 1'b0; IsByteW_in = 1'b0;
    ra1 = 5'd5; ra2 = 5'd5;

    // reset held with a write request pending
    repeat (2) @(posedge clk);
    step(); #1;
    expect_val("rst_rd1", 32'h0);      check(rd1);
    expect_val("rst_rd2", 32'h0);      check(rd2);
    expect_val("rst_we", 32'h0);       check({31'h0, wb_we});
    expect_val("rst_addr", 32'd5);     check({27'h0, wb_addr});
    expect_val("rst_data", 32'h1234);  check(wb_data);
    RegWr_in = 1'b0;
    step(); rst_n = 1'b1;
    step(); #1;
    expect_val("post_rst_r5", 32'h0);  check(rd1);

    // ALU write with bypass
    step(); RegDst_in = 1'b1; rd_in = 5'd8; Result_in = 32'hDEADBEEF; RegWr_in = 1'b1; ra1 = 5'd8;
    #1;
    expect_val("alu_bypass", 32'hDEADBEEF); check(rd1);
    expect_val("alu_we", 32'h1);            check({31'h0, wb_we});
    step(); RegWr_in = 1'b0; Result_in = 32'h0; #1;
    expect_val("alu_stored", 32'hDEADBEEF); check(rd1);

    // byte loads into rt=9
    step(); dm_read_in = 32'h80FF7F01; MemtoReg_in = 1'b1; IsByteW_in = 1'b1;
    rt_in = 5'd9; RegDst_in = 1'b0; RegWr_in = 1'b1; Result_in = 32'h3; ExtopM_in = 1'b1; ra1 = 5'd9;
    #1;
    expect_val("lb_lane3", 32'hFFFFFF80);   check(wb_data);
    expect_val("lb_lane3_byp", 32'hFFFFFF80); check(rd1);
    step(); Result_in = 32'h2; ExtopM_in = 1'b0; #1;
    expect_val("lbu_lane2", 32'h000000FF);  check(wb_data);
    step(); Result_in = 32'h1; ExtopM_in = 1'b1; #1;
    expect_val("lb_lane1", 32'h0000007F);   check(wb_data);
    step(); Result_in = 32'h0; #1;
    expect_val("lb_lane0", 32'h00000001);   check(wb_data);
    step(); RegWr_in = 1'b0; #1;
    expect_val("lb_stored", 32'h00000001);  check(rd1);
    step(); IsByteW_in = 1'b0; #1;
    expect_val("lw_word", 32'h80FF7F01);    check(wb_data);
    step(); MemtoReg_in = 1'b0; IsByteW_in = 1'b1; Result_in = 32'h13572468; #1;
    expect_val("byte_ignored", 32'h13572468); check(wb_data);
    IsByteW_in = 1'b0;

    // link
    step(); IsLink_in = 1'b1; pc_in = 32'h00400010; rd_in = 5'd4; RegDst_in = 1'b1; RegWr_in = 1'b1; #1;
    expect_val("link_addr", 32'd31);        check({27'h0, wb_addr});
    expect_val("link_data", 32'h00400014);  check(wb_data);
    step(); RegWr_in = 1'b0; IsLink_in = 1'b0; ra1 = 5'd31; ra2 = 5'd4; #1;
    expect_val("link_r31", 32'h00400014);   check(rd1);
    expect_val("link_r4", 32'h0);           check(rd2);
    step(); IsLink_in = 1'b1; pc_in = 32'hFFFFFFFC; RegWr_in = 1'b1; #1;
    expect_val("link_wrap", 32'h0);         check(wb_data);
    step(); RegWr_in = 1'b0; IsLink_in = 1'b0; #1;
    expect_val("link_wrap_r31", 32'h0);     check(rd1);

    // $0 protection
    step(); RegWr_in = 1'b1; rt_in = 5'd0; RegDst_in = 1'b0; Result_in = 32'hFFFFFFFF; ra1 = 5'd0; #1;
    expect_val("r0_we", 32'h0);             check({31'h0, wb_we});
    expect_val("r0_before", 32'h0);         check(rd1);
    step(); RegWr_in = 1'b0; #1;
    expect_val("r0_after", 32'h0);          check(rd1);

    // dual read
    step(); RegWr_in = 1'b1; RegDst_in = 1'b1; rd_in = 5'd13; Result_in = 32'hAA;
    step(); rd_in = 5'd12; Result_in = 32'h55; ra1 = 5'd12; ra2 = 5'd12; #1;
    expect_val("dual_byp1", 32'h55);        check(rd1);
    expect_val("dual_byp2", 32'h55);        check(rd2);
    step(); RegWr_in = 1'b0; ra2 = 5'd13; #1;
    expect_val("dual_r12", 32'h55);         check(rd1);
    expect_val("dual_r13", 32'hAA);         check(rd2);

    // reset asserted during a write: reset wins, first write after release
    step(); RegWr_in = 1'b1; rd_in = 5'd12; Result_in = 32'h77; rst_n = 1'b0; ra2 = 5'd13;
    @(posedge clk); #1;
    expect_val("rstw_r12", 32'h0);          check(rd1);
    step(); #1;
    expect_val("rstw_r13", 32'h0);          check(rd2);
    rst_n = 1'b1;
    step(); RegWr_in = 1'b0; #1;
    expect_val("rstw_first", 32'h77);       check(rd1);
    expect_val("rstw_r13_clr", 32'h0);      check(rd2);

    // X on inputs with RegWr_in low must not corrupt state
    step(); Result_in = 'x; dm_read_in = 'x; pc_in = 'x; rd_in = 'x; rt_in = 'x;
    RegDst_in = 1'bx; MemtoReg_in = 1'bx; IsLink_in = 1'bx; IsByteW_in = 1'bx; ExtopM_in = 1'bx;
    repeat (2) @(posedge clk);
    step(); #1;
    expect_val("x_we", 32'h0);              check({31'h0, wb_we});
    expect_val("x_r12", 32'h77);            check(rd1);
    expect_val("x_r13", 32'h0);             check(rd2);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
